// File: rtl/stream_demux_1_4.sv
// 1-to-4 valid/ready stream demultiplexer with one register stage per channel.
// Destination comes from in_sel or from an internal round-robin pointer.
module stream_demux_1_4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rr_mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] out_data0,
    output logic [W-1:0] out_data1,
    output logic [W-1:0] out_data2,
    output logic [W-1:0] out_data3,
    output logic [1:0]   rr_ptr
);

    logic [3:0]   r_valid;
    logic [W-1:0] r_data [4];
    logic [1:0]   r_ptr;

    logic [1:0]   w_dst;
    logic [3:0]   w_free;
    logic         w_acc;

    assign w_dst  = rr_mode ? r_ptr : in_sel;
    assign w_free = ~r_valid | out_ready;
    // Held in reset so in_ready shows the cleared state before the edge
    assign in_ready = ~rst_n | w_free[w_dst];
    assign w_acc    = in_valid & w_free[w_dst];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 4'b0000;
            r_ptr   <= 2'd0;
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_acc && (w_dst == 2'(k))) begin
                    r_data[k]  <= in_data;
                    r_valid[k] <= 1'b1;
                end else if (out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            if (w_acc && rr_mode) begin
                r_ptr <= r_ptr + 2'd1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data0 = r_data[0];
    assign out_data1 = r_data[1];
    assign out_data2 = r_data[2];
    assign out_data3 = r_data[3];
    assign rr_ptr    = r_ptr;

endmodule
